// File: rtl/dnlink_tx.sv
// Downlink telemetry serializer: sync marker, 16 data bits MSB first,
// odd parity bit, then a one-cycle done pulse and a frame counter bump.
module dnlink_tx #(
    parameter int BIT_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic        load,
    output logic        ready,
    output logic        busy,
    output logic        sync_out,
    output logic        data_out,
    output logic        bit_clk_out,
    output logic        done,
    output logic [7:0]  frame_cnt
);

    localparam int PW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(BIT_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(BIT_DIV / 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    frame_q, frame_d;
    logic          wrap;

    assign wrap = (phase_q == PH_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = word_in;
                    par_d   = ~^word_in;
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                phase_d = wrap ? '0 : phase_q + PW'(1);
                if (wrap) begin
                    bit_d   = 4'd15;
                    state_d = DATA;
                end
            end
            DATA: begin
                phase_d = wrap ? '0 : phase_q + PW'(1);
                // Shift only on the period boundary so data moves at phase 0.
                if (wrap) begin
                    shift_d = {shift_q[14:0], 1'b0};
                    if (bit_q == 4'd0) state_d = PARITY;
                    else               bit_d   = bit_q - 4'd1;
                end
            end
            PARITY: begin
                phase_d = wrap ? '0 : phase_q + PW'(1);
                if (wrap) state_d = DONE;
            end
            DONE: begin
                frame_d = frame_q + 8'd1;
                phase_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == IDLE);
        busy        = (state_q == SYNC) || (state_q == DATA) ||
                      (state_q == PARITY);
        sync_out    = (state_q == SYNC);
        done        = (state_q == DONE);
        bit_clk_out = busy && (phase_q >= PH_HALF);
        data_out    = 1'b0;
        if (state_q == DATA)   data_out = shift_q[15];
        if (state_q == PARITY) data_out = par_q;
    end

    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_dnlink_tx.sv
// Directed bench for dnlink_tx: vector table of words plus reset,
// load-hold and frame counter wrap sequences.
module tb_dnlink_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_in;
    logic        load;
    logic        ready, busy, sync_out, data_out, bit_clk_out, done;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad = 0;

    dnlink_tx #(.BIT_DIV(4)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .load(load),
        .ready(ready), .busy(busy), .sync_out(sync_out),
        .data_out(data_out), .bit_clk_out(bit_clk_out),
        .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        par;
        logic [7:0]  frame;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] fr);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_outs"},
              {busy, sync_out, data_out, bit_clk_out, done}, 0);
        check({tag, "_frame"}, frame_cnt, fr);
    endtask

    // Caller is 1 time unit after a posedge with the DUT idle.
    task automatic run_word(input logic [15:0] w, input logic p,
                            input logic [7:0] fr, input bit hold,
                            input string tag);
        int n_sync = 0, n_data = 0, n_bclk = 0;
        int n_busy = 0, n_rdy = 0, n_done = 0;
        int done_at = -1;
        logic e_sync, e_data, e_bclk, e_busy, e_done, e_rdy;
        word_in = w;
        load    = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            @(posedge clk);
            #1;
            if (!hold && k == 1) load = 1'b0;
            if (hold) word_in = 16'($urandom);
            e_sync = (k >= 1 && k <= 4);
            e_busy = (k >= 1 && k <= 72);
            e_bclk = e_busy && (((k - 1) % 4) >= 2);
            e_done = (k == 73);
            e_rdy  = (k == 74);
            e_data = 1'b0;
            if (k >= 5 && k <= 68) e_data = w[15 - (k - 5) / 4];
            if (k >= 69 && k <= 72) e_data = p;
            if (sync_out !== e_sync) n_sync++;
            if (data_out !== e_data) n_data++;
            if (bit_clk_out !== e_bclk) n_bclk++;
            if (busy !== e_busy) n_busy++;
            if (ready !== e_rdy) n_rdy++;
            if (done) begin
                n_done++;
                done_at = k;
            end
            if (done !== e_done) n_done += 100;
            if (k == 74) begin
                load = 1'b0;
                check({tag, "_frame"}, frame_cnt, fr);
            end
        end
        check({tag, "_sync_bad_cycles"}, n_sync, 0);
        check({tag, "_data_bad_cycles"}, n_data, 0);
        check({tag, "_bitclk_bad_cycles"}, n_bclk, 0);
        check({tag, "_busy_bad_cycles"}, n_busy, 0);
        check({tag, "_ready_bad_cycles"}, n_rdy, 0);
        check({tag, "_done_cycle"}, done_at, 73);
        check({tag, "_done_pulses"}, n_done, 1);
    endtask

    initial begin
        vecs[0] = '{16'hA5A5, 1'b1, 8'd1};
        vecs[1] = '{16'h0001, 1'b0, 8'd2};
        vecs[2] = '{16'h0000, 1'b1, 8'd3};
        vecs[3] = '{16'hFFFF, 1'b1, 8'd4};
        vecs[4] = '{16'h8000, 1'b0, 8'd5};
        vecs[5] = '{16'h1234, 1'b0, 8'd6};

        // Reset held with load high: load must be ignored.
        rst = 1'b0;
        load = 1'b1;
        word_in = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 8'd0);
        load = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("post_release_ready", ready, 1);

        // Asynchronous reset at cycle 30 of a word.
        word_in = 16'hA5A5;
        load = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            load = 1'b0;
        end
        check("midword_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_idle("async_reset", 8'd0);
        @(posedge clk);
        #1;
        check("reset_no_done", done, 0);
        rst = 1'b1;

        foreach (vecs[i])
            run_word(vecs[i].word, vecs[i].par, vecs[i].frame, 1'b0,
                     $sformatf("vec%0d", i));

        // Load held high for the whole word with changing word_in.
        run_word(16'h5A3C, 1'b1, 8'd7, 1'b1, "hold");
        @(posedge clk);
        #1;
        check("hold_idle_after", ready, 1);

        // Frame counter wrap over 256 words.
        rst = 1'b0;
        #1;
        check("wrap_reset_frame", frame_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            logic [15:0] w;
            w = 16'(i * 16'h0101 + 16'h0037);
            run_word(w, ~^w, 8'(i), 1'b0, $sformatf("wrap%0d", i));
            if (i == 255) check("frame_after_255", frame_cnt, 8'd255);
            if (i == 256) check("frame_after_256", frame_cnt, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dnlink_tx.md
DNLINK_TX -- requirements
Module: dnlink_tx

Interface
REQ-001 Parameter BIT_DIV, default 4: clk cycles per serial bit period; SHALL be even and >= 2.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on posedge clk.
REQ-003 Port rst, input, 1: reset, asynchronous, active-low (rst=0 resets).
REQ-004 Port word_in, input, 16: telemetry word, sampled only on an accepted load.
REQ-005 Port load, input, 1: request strobe; accepted only when ready=1.
REQ-006 Port ready, output, 1: high when idle and able to accept load.
REQ-007 Port busy, output, 1: high from the cycle after acceptance through the PARITY state.
REQ-008 Port sync_out, output, 1: word-start marker, high for the whole SYNC state.
REQ-009 Port data_out, output, 1: serial data line.
REQ-010 Port bit_clk_out, output, 1: serial bit clock for the receiving end.
REQ-011 Port done, output, 1: one-cycle pulse marking end of word.
REQ-012 Port frame_cnt, output, 8: count of completed words.

Function
REQ-013 The FSM SHALL have states IDLE, SYNC, DATA, PARITY and DONE, each with a distinct encoding.
REQ-014 IDLE: ready=1, busy=0, sync_out=0, data_out=0, bit_clk_out=0, done=0.
REQ-015 In IDLE with load=1 at a posedge: capture word_in into the shift register, compute odd parity, clear the phase and bit counters, go to SYNC.
REQ-016 load while ready=0 SHALL be ignored, with no effect on the word in flight.
REQ-017 Phase counter: 0..BIT_DIV-1, wraps at each bit-period boundary.
REQ-018 bit_clk_out = 1 when phase >= BIT_DIV/2 in SYNC, DATA or PARITY; else 0.
REQ-019 data_out SHALL change only at phase 0, so it is stable across the rising edge of bit_clk_out.
REQ-020 SYNC: lasts exactly BIT_DIV cycles; sync_out=1, data_out=0.
REQ-021 DATA: 16 bit periods, MSB first (word bit 15 first); the bit counter runs 15 down to 0.
REQ-022 PARITY: one bit period; data_out = odd-parity bit, so ones(word)+parity is odd.
REQ-023 DONE: exactly one cycle; done=1, ready=0, busy=0, and frame_cnt increments.
REQ-024 The state after DONE SHALL be IDLE; load is not accepted in the DONE cycle.
REQ-025 Latency: with load accepted at edge 0, SYNC occupies cycles 1..BIT_DIV, DATA BIT_DIV+1..17*BIT_DIV, PARITY 17*BIT_DIV+1..18*BIT_DIV, and done=1 in cycle 18*BIT_DIV+1.
REQ-026 frame_cnt is modulo 256 and SHALL wrap from 255 to 0.
REQ-027 Back-to-back: the minimum spacing between accepted loads is 18*BIT_DIV+2 cycles.

Reset
REQ-028 rst=0 SHALL force, immediately and without waiting for clk, state=IDLE, ready=1, and busy, sync_out, data_out, bit_clk_out and done all 0.
REQ-029 Reset SHALL also force frame_cnt=0, shift register=0 and counters=0.
REQ-030 Reset mid-word SHALL discard the word; no done pulse, no frame_cnt increment.
REQ-031 Reset release coinciding with load=1: the load SHALL be ignored if rst is low at that posedge.

Verification
REQ-032 BIT_DIV=4, load word_in=16'hA5A5 -> sync_out high for cycles 1-4; data_out sequence 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 with each bit held 4 cycles; parity bit=1; done=1 at cycle 73; frame_cnt=1.
REQ-033 word_in=16'h0001 -> parity bit 0; word_in=16'h0000 -> parity bit 1; data_out 0 for all data bits.
REQ-034 Reassert load every cycle during a word -> only the first is accepted; the serial stream equals the first word_in; one done pulse.
REQ-035 Assert rst=0 at cycle 30 of a word -> outputs return to idle values asynchronously; no done; frame_cnt unchanged at 0; a new load after release transmits correctly.
REQ-036 Send 256 words back-to-back -> frame_cnt reads 255 after the 255th done and 0 after the 256th done.
REQ-037 For every bit period, bit_clk_out is low at phases 0-1 and high at phases 2-3, and data_out is stable across each bit_clk_out rising edge.
